// File: rtl/mmio_decoder_v2_if.sv
// Core data-port / MMIO device bundle for mmio_decoder_v2.
// The master side drives requests and device responses; the slave side is the decoder.
interface mmio_decoder_v2_if #(
  parameter int NUM_SLOTS = 32
);
  logic [31:0]             data_address;
  logic [31:0]             data_store;
  logic                    data_read;
  logic                    data_enable;
  logic                    data_stall;
  logic [31:0]             data_fetch;
  logic                    rsp_valid;
  logic                    bus_error;
  logic [NUM_SLOTS-1:0]    mmio_sel;
  logic [32*NUM_SLOTS-1:0] dev_rdata;
  logic [NUM_SLOTS-1:0]    dev_ready;
  logic                    cache_access;
  logic                    cache_access_ff;

  modport master (
    output data_address, data_store, data_read, data_enable, dev_rdata, dev_ready,
    input  data_stall, data_fetch, rsp_valid, bus_error, mmio_sel, cache_access,
           cache_access_ff
  );

  modport slave (
    input  data_address, data_store, data_read, data_enable, dev_rdata, dev_ready,
    output data_stall, data_fetch, rsp_valid, bus_error, mmio_sel, cache_access,
           cache_access_ff
  );
endinterface

// File: rtl/mmio_decoder_v2.sv
// MMIO decoder/arbiter: splits data accesses between cache and NUM_SLOTS devices.
// Optional build macro MMIO_LOCK_EN adds a sticky lock register at slot-0 offset +16.
module mmio_decoder_v2 #(
  parameter int          NUM_SLOTS      = 32,
  parameter int          SLOT_BYTES     = 1024,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] RESET_BASE     = 32'h0020_0000,
  parameter logic [31:0] RESET_BOUND    = 32'h0040_0000
) (
  input logic               clk,
  input logic               rst_n,
  mmio_decoder_v2_if.slave  bus
);

  localparam int OFF_W = $clog2(SLOT_BYTES);
  localparam int TW    = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state_q;
  logic [NUM_SLOTS-1:0] mmio_sel_q;
  logic [TW-1:0]        timer_q;
  logic                 rd_q;
  logic                 rsp_valid_q;
  logic                 bus_error_q;
  logic [31:0]          data_fetch_q;
  logic                 cache_ff_q;
  logic [31:0]          base_q;
  logic [31:0]          bound_q;
  logic [31:0]          shadow_base_q;
  logic [31:0]          shadow_bound_q;

  logic                 live_ok;
  logic [31:0]          act_base;
  logic [31:0]          act_bound;
  logic                 is_mmio;
  logic [31:0]          diff;
  logic [31:0]          slot_num;
  logic                 mapped;
  logic                 is_slot0;
  logic                 req;
  logic                 dev_req;
  logic                 ready_hit;
  logic                 timeout;
  logic                 wr_allow;
  logic [NUM_SLOTS-1:0] mmio_sel_d;
  logic [31:0]          ctrl_rdata_d;
  logic [31:0]          sel_rdata_d;

  // A live pair with bound <= base is treated as a misconfiguration; fall back to shadow.
  assign live_ok   = bound_q > base_q;
  assign act_base  = live_ok ? base_q  : shadow_base_q;
  assign act_bound = live_ok ? bound_q : shadow_bound_q;

  assign is_mmio   = (bus.data_address >= act_base) && (bus.data_address < act_bound);
  assign diff      = bus.data_address - act_base;
  assign slot_num  = diff >> OFF_W;
  assign mapped    = slot_num < 32'(NUM_SLOTS);
  assign is_slot0  = slot_num == 32'd0;

  // RESP accepts new work exactly like IDLE, so only BUSY blocks acceptance.
  assign req       = (state_q != BUSY) && bus.data_enable && is_mmio;
  assign dev_req   = req && mapped && !is_slot0;
  assign ready_hit = |(bus.dev_ready & mmio_sel_q);
  assign timeout   = timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign mmio_sel_d = NUM_SLOTS'(1) << slot_num;

`ifdef MMIO_LOCK_EN
  logic lock_q;
  assign wr_allow = !lock_q;
`else
  assign wr_allow = 1'b1;
`endif

  always_comb begin
    ctrl_rdata_d = '0;
    if (diff == 32'd8)       ctrl_rdata_d = base_q;
    else if (diff == 32'd12) ctrl_rdata_d = bound_q;
`ifdef MMIO_LOCK_EN
    else if (diff == 32'd16) ctrl_rdata_d = {31'b0, lock_q};
`endif
  end

  always_comb begin
    sel_rdata_d = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (mmio_sel_q[k]) sel_rdata_d = sel_rdata_d | bus.dev_rdata[32*k +: 32];
    end
  end

  assign bus.data_stall      = dev_req || ((state_q == BUSY) && !ready_hit && !timeout);
  assign bus.cache_access    = bus.data_enable && !is_mmio;
  assign bus.cache_access_ff = cache_ff_q;
  assign bus.data_fetch      = data_fetch_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.bus_error       = bus_error_q;
  assign bus.mmio_sel        = mmio_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      mmio_sel_q     <= '0;
      timer_q        <= '0;
      rd_q           <= 1'b0;
      rsp_valid_q    <= 1'b0;
      bus_error_q    <= 1'b0;
      data_fetch_q   <= '0;
      cache_ff_q     <= 1'b1;
      base_q         <= RESET_BASE;
      bound_q        <= RESET_BOUND;
      shadow_base_q  <= RESET_BASE;
      shadow_bound_q <= RESET_BOUND;
`ifdef MMIO_LOCK_EN
      lock_q         <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      bus_error_q <= 1'b0;
      cache_ff_q  <= bus.cache_access;

      if (live_ok) begin
        shadow_base_q  <= base_q;
        shadow_bound_q <= bound_q;
      end

      // Control-register writes land on the edge that accepts the slot-0 store.
      if (req && is_slot0 && !bus.data_read) begin
        if (diff == 32'd0 && wr_allow) base_q  <= bus.data_store;
        if (diff == 32'd4 && wr_allow) bound_q <= bus.data_store;
`ifdef MMIO_LOCK_EN
        if (diff == 32'd16 && bus.data_store[0]) lock_q <= 1'b1;
`endif
      end

      case (state_q)
        IDLE, RESP: begin
          state_q <= IDLE;
          if (req) begin
            if (!mapped) begin
              state_q      <= RESP;
              rsp_valid_q  <= 1'b1;
              bus_error_q  <= 1'b1;
              data_fetch_q <= 32'hFFFF_FFFF;
            end else if (is_slot0) begin
              state_q      <= RESP;
              rsp_valid_q  <= 1'b1;
              data_fetch_q <= bus.data_read ? ctrl_rdata_d : 32'h0;
            end else begin
              state_q    <= BUSY;
              mmio_sel_q <= mmio_sel_d;
              rd_q       <= bus.data_read;
              timer_q    <= '0;
            end
          end
        end
        BUSY: begin
          timer_q <= timer_q + 1'b1;
          if (ready_hit) begin
            state_q      <= RESP;
            mmio_sel_q   <= '0;
            rsp_valid_q  <= 1'b1;
            data_fetch_q <= rd_q ? sel_rdata_d : 32'h0;
          end else if (timeout) begin
            state_q      <= RESP;
            mmio_sel_q   <= '0;
            rsp_valid_q  <= 1'b1;
            bus_error_q  <= 1'b1;
            data_fetch_q <= 32'hFFFF_FFFF;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
